fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline, the producer side of the IF/ID interface consumed by decode. Owns the PC register and issues one-outstanding, in-order requests to instruction memory. Registers {PC, PC+4, instruction, prediction} into the IF/ID pipeline register. Accepts redirects from the branch, trap and mret paths, and trains a BHT/BTB predictor from resolved branches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BHT_ENTRIES, 64, predictor entries (power of two); index = PC[log2(BHT_ENTRIES)+1:2]

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- keep  in  1  decode stall; hold IF/ID outputs
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart address; bits [1:0] are ignored and treated as 0
- bht_update_valid  in  1  resolved conditional branch or jal
- bht_update_pc  in  32  PC of the resolved instruction
- bht_update_taken  in  1  actual outcome
- bht_update_target  in  32  actual target
- imem_req  out  1  request strobe, combinational
- imem_addr  out  32  request address, word aligned
- imem_rvalid  in  1  response valid; at least 1 cycle after req; in order
- imem_rdata  in  32  instruction word
- PC_pype0  out  32  fetched PC
- PCp4_pype0  out  32  PC+4
- Instraction_pype  out  32  instruction; 32'h0000_0013 when invalid
- inst_valid  out  1  IF/ID holds a real instruction
- is_branch_predict  out  1  predicted taken
- PC_Np_pype0  out  32  predicted next PC

## Operation
- Three states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DROP: outstanding request is stale; its response is discarded.
- **Reset values:** pc = RESET_PC; state = IDLE; skid buffer empty; all BHT counters = 2'b01; BTB valid bits = 0. Outputs: PC_pype0 = 0, PCp4_pype0 = 0, Instraction_pype = 32'h13, inst_valid = 0, is_branch_predict = 0, PC_Np_pype0 = 0.
- **Request issue:** imem_req = 1 when all of the following hold:
  - state is IDLE, or state is WAIT with imem_rvalid high;
  - skid buffer is empty;
  - redirect_valid is low;
  - rst is low.
- **Address:** imem_addr = pc. On issue, pc updates to the predicted next PC, state goes to WAIT.
- **Prediction:** taken when the BHT counter is ≥ 2'b10 and the BTB entry is valid with a tag match (PC[31:idx_msb+1]). Predicted next PC = BTB target if taken, else pc+4. The prediction is carried with the request and delivered to decode with its response.
- **Response accept:**
  - keep = 0: IF/ID registers load {PC, PC+4, rdata, prediction} and inst_valid = 1.
  - keep = 1: the response is written into a 1-entry skid buffer and the outputs hold.
  - If no response arrives and keep = 0, the outputs become a bubble (inst_valid = 0, NOP).
- **Skid drain:** first cycle with keep = 0, the skid entry loads into IF/ID. Fetch resumes in the same cycle.
- **Redirect:**
  - Has priority over keep.
  - pc ← redirect_pc; skid buffer cleared; IF/ID becomes a bubble.
  - If state is WAIT and rvalid is low, go to DROP; else go to IDLE.
  - DROP returns to IDLE on rvalid and discards that response.
- **BHT/BTB update:** saturating 2-bit counter, incremented on taken, decremented on not-taken. On taken, the BTB tag and target are written and valid is set. An update in the same cycle as a lookup of the same index: the lookup sees the old value.
- **PC arithmetic:** 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- First imem_req: the first cycle after rst falls, address RESET_PC.
- Latency: request in cycle N, rvalid in cycle N+1, IF/ID valid in cycle N+2.
- Throughput: with 1-cycle memory, one instruction per cycle.
- After a redirect in cycle R:
  - from IDLE, a request at redirect_pc is issued in R+1;
  - from DROP, the request is issued in the cycle after the stale rvalid.
- Redirect and rvalid in the same cycle: the response is discarded and the state goes to IDLE.
- rst wins over every other input. The memory shares rst, so no response crosses reset.

## Configuration
- BRANCH_PREDICT_EN defined: BHT/BTB instantiated, prediction as above.
- BRANCH_PREDICT_EN undefined: predictor not instantiated. is_branch_predict = 0 and PC_Np_pype0 = PC+4 always. bht_update_* are ignored.

## Structure
- Shared package holds:
  - NOP encoding 32'h0000_0013;
  - fetch-state enum {IDLE, WAIT, DROP};
  - the 2-bit counter constants: weak-not-taken 2'b01, taken threshold 2'b10.
- Sub-module branch_predictor holds the BHT/BTB arrays, the combinational lookup port and the synchronous update port. It is instantiated only under BRANCH_PREDICT_EN.

## Test plan
- Reset then run a 1-cycle memory returning mem[a] = a → imem_addr 0, 4, 8 on consecutive cycles; inst_valid first high 2 cycles after the first req; Instraction_pype = 0, 4, 8.
- keep high for 3 cycles while responses arrive → outputs frozen; one response held in skid and requests stop; on release the skid word appears next cycle with no instruction lost or duplicated.
- redirect_valid with redirect_pc = 32'h100 while WAIT and rvalid low → DROP; the stale response is discarded; the next req is at 32'h100; IF/ID bubble in between.
- Two bht_update taken for pc = 32'h40 with target 32'h80, then fetch 32'h40 → is_branch_predict = 1 and PC_Np_pype0 = 32'h80; the next imem_addr is 32'h80. Without BRANCH_PREDICT_EN → 0 and 32'h44.
- Redirect to 32'hFFFF_FFFC → PCp4_pype0 = 0 and the next imem_addr = 0.
- rst asserted in WAIT → all outputs return to reset values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage and its branch predictor.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] CNT_WEAK_NT  = 2'b01;
  localparam logic [1:0] CNT_TAKEN_TH = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_branch_predictor.sv
// BHT (2-bit saturating counters) plus direct-mapped BTB: combinational lookup, same-cycle lookups see pre-update state.
// Single-cycle synchronous update port; never stalls.
module branch_predictor
  import fetch_unit_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lookup_pc,
  output logic        o_taken,
  output logic [31:0] o_target,
  input  logic        i_upd_vld,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [1:0]       r_bht     [ENTRIES];
  logic             r_btb_vld [ENTRIES];
  logic [TAG_W-1:0] r_btb_tag [ENTRIES];
  logic [31:0]      r_btb_tgt [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_unused_lo;

  assign w_lk_idx    = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag    = i_lookup_pc[31:IDX_W+2];
  assign w_up_idx    = i_upd_pc[IDX_W+1:2];
  assign w_unused_lo = ^{i_lookup_pc[1:0], i_upd_pc[1:0], i_upd_target[1:0]};

  assign o_taken  = (r_bht[w_lk_idx] >= CNT_TAKEN_TH) && r_btb_vld[w_lk_idx] &&
                    (r_btb_tag[w_lk_idx] == w_lk_tag);
  assign o_target = r_btb_tgt[w_lk_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i]     <= CNT_WEAK_NT;
        r_btb_vld[i] <= 1'b0;
      end
    end else if (i_upd_vld) begin
      if (i_upd_taken) begin
        if (r_bht[w_up_idx] != 2'b11) r_bht[w_up_idx] <= r_bht[w_up_idx] + 2'd1;
        r_btb_vld[w_up_idx] <= 1'b1;
        r_btb_tag[w_up_idx] <= i_upd_pc[31:IDX_W+2];
        r_btb_tgt[w_up_idx] <= {i_upd_target[31:2], 2'b00};
      end else if (r_bht[w_up_idx] != 2'b00) begin
        r_bht[w_up_idx] <= r_bht[w_up_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I IF stage: one outstanding imem request, IF/ID valid 2 cycles after request; keep parks a response in a 1-entry skid.
// BHT/BTB prediction is built only when BRANCH_PREDICT_EN is defined; otherwise next PC is always PC+4.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        bht_update_valid,
  input  logic [31:0] bht_update_pc,
  input  logic        bht_update_taken,
  input  logic [31:0] bht_update_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        inst_valid,
  output logic        is_branch_predict,
  output logic [31:0] PC_Np_pype0
);

  fetch_state_e r_state;
  logic [31:0]  r_pc, r_req_pc, r_req_npc;
  logic         r_req_taken;
  logic         r_skid_vld, r_skid_taken;
  logic [31:0]  r_skid_pc, r_skid_inst, r_skid_npc;
  logic [31:0]  r_if_pc, r_if_pcp4, r_if_inst, r_if_npc;
  logic         r_if_vld, r_if_taken;

  logic         w_pred_taken, w_rsp, w_to_skid, w_issue;
  logic [31:0]  w_pc_p4, w_pred_npc;

  assign w_pc_p4 = r_pc + 32'd4;

`ifdef BRANCH_PREDICT_EN
  logic [31:0] w_btb_tgt;
  logic        w_unused_rd;

  branch_predictor #(.ENTRIES(BHT_ENTRIES)) u_bp (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_lookup_pc  (r_pc),
    .o_taken      (w_pred_taken),
    .o_target     (w_btb_tgt),
    .i_upd_vld    (bht_update_valid),
    .i_upd_pc     (bht_update_pc),
    .i_upd_taken  (bht_update_taken),
    .i_upd_target (bht_update_target)
  );
  assign w_pred_npc  = w_pred_taken ? w_btb_tgt : w_pc_p4;
  assign w_unused_rd = ^redirect_pc[1:0];
`else
  logic w_unused_bp;
  assign w_pred_taken = 1'b0;
  assign w_pred_npc   = w_pc_p4;
  assign w_unused_bp  = ^{bht_update_valid, bht_update_pc, bht_update_taken, bht_update_target,
                          redirect_pc[1:0], (BHT_ENTRIES > 0)};
`endif

  // A response parked in the skid blocks issue, so a second one can never arrive while it is full;
  // a skid being drained this cycle (keep low) frees the slot and lets fetch resume at once.
  assign w_rsp     = (r_state == WAIT) && imem_rvalid;
  assign w_to_skid = w_rsp && keep;
  assign w_issue   = !rst && !redirect_valid && ((r_state == IDLE) || w_rsp) &&
                     (r_skid_vld ? !keep : !w_to_skid);

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;

  assign PC_pype0          = r_if_pc;
  assign PCp4_pype0        = r_if_pcp4;
  assign Instraction_pype  = r_if_inst;
  assign inst_valid        = r_if_vld;
  assign is_branch_predict = r_if_taken;
  assign PC_Np_pype0       = r_if_npc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req_pc     <= '0;
      r_req_npc    <= '0;
      r_req_taken  <= 1'b0;
      r_skid_vld   <= 1'b0;
      r_skid_taken <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_inst  <= NOP_INST;
      r_skid_npc   <= '0;
      r_if_pc      <= '0;
      r_if_pcp4    <= '0;
      r_if_inst    <= NOP_INST;
      r_if_vld     <= 1'b0;
      r_if_taken   <= 1'b0;
      r_if_npc     <= '0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_skid_vld <= 1'b0;
      r_state    <= ((r_state != IDLE) && !imem_rvalid) ? DROP : IDLE;
      r_if_inst  <= NOP_INST;
      r_if_vld   <= 1'b0;
      r_if_taken <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_issue) r_state <= WAIT;
        WAIT:    if (imem_rvalid) r_state <= w_issue ? WAIT : IDLE;
        DROP:    if (imem_rvalid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_issue) begin
        r_pc        <= w_pred_npc;
        r_req_pc    <= r_pc;
        r_req_npc   <= w_pred_npc;
        r_req_taken <= w_pred_taken;
      end

      if (w_to_skid) begin
        r_skid_vld   <= 1'b1;
        r_skid_pc    <= r_req_pc;
        r_skid_inst  <= imem_rdata;
        r_skid_npc   <= r_req_npc;
        r_skid_taken <= r_req_taken;
      end

      if (!keep) begin
        if (r_skid_vld) begin
          r_skid_vld <= 1'b0;
          r_if_pc    <= r_skid_pc;
          r_if_pcp4  <= r_skid_pc + 32'd4;
          r_if_inst  <= r_skid_inst;
          r_if_npc   <= r_skid_npc;
          r_if_taken <= r_skid_taken;
          r_if_vld   <= 1'b1;
        end else if (w_rsp) begin
          r_if_pc    <= r_req_pc;
          r_if_pcp4  <= r_req_pc + 32'd4;
          r_if_inst  <= imem_rdata;
          r_if_npc   <= r_req_npc;
          r_if_taken <= r_req_taken;
          r_if_vld   <= 1'b1;
        end else begin
          r_if_inst  <= NOP_INST;
          r_if_vld   <= 1'b0;
          r_if_taken <= 1'b0;
        end
      end
    end
  end

endmodule
